// File: rtl/keypad_scan_pkg.sv
// Shared types and default constants for the hexadecimal keypad scanner.
package keypad_scan_pkg;

   localparam int unsigned ROWS_DEFAULT            = 4;
   localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } debounce_state_t;

endpackage

// File: rtl/keypad_row_debouncer_sync.sv
// Per-bit flop-chain synchroniser; bits are never combined before the last stage.
module bit_synchronizer #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage <= '0;
      end else begin
         stage <= {stage[STAGES-2:0], d};
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/keypad_row_debouncer.sv
// Row-input conditioner: synchronise, debounce the whole vector, and flag key
// presence, multiple keys and press/release transitions.
module keypad_row_debouncer
   import keypad_scan_pkg::*;
#(
   parameter int unsigned ROWS            = ROWS_DEFAULT,
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [ROWS-1:0] row,
   output logic [ROWS-1:0] s_row,
   output logic            any_key,
   output logic            multi_key,
   output logic            press_pulse,
   output logic            release_pulse
);

   localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [ROWS-1:0]  sync_row;
   logic [ROWS-1:0]  candidate;
   logic [CW-1:0]    cnt;
   debounce_state_t  state;

   bit_synchronizer #(
      .WIDTH  (ROWS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (row),
      .q     (sync_row)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         candidate     <= '0;
         cnt           <= '0;
         s_row         <= '0;
         any_key       <= 1'b0;
         multi_key     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_row != s_row) begin
                  candidate <= sync_row;
                  cnt       <= CW'(1);
                  state     <= CHECK;
               end
            end
            CHECK: begin
               if (sync_row == s_row) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (sync_row != candidate) begin
                  candidate <= sync_row;
                  cnt       <= CW'(1);
               end else if (cnt == CNT_LAST) begin
                  s_row         <= candidate;
                  any_key       <= |candidate;
                  // Clearing the lowest set bit leaves something only if two or more were set.
                  multi_key     <= |(candidate & (candidate - ROWS'(1)));
                  press_pulse   <= (s_row == '0) && (candidate != '0);
                  release_pulse <= (s_row != '0) && (candidate == '0);
                  cnt           <= '0;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_row_debouncer.sv
// Scoreboard bench: a history-based reference model predicts commits, a monitor checks them.
module tb_keypad_row_debouncer;

   localparam int unsigned ROWS = 4;
   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [ROWS-1:0] row   = '0;
   logic [ROWS-1:0] s_row;
   logic            any_key, multi_key, press_pulse, release_pulse;

   keypad_row_debouncer #(
      .ROWS            (ROWS),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .row           (row),
      .s_row         (s_row),
      .any_key       (any_key),
      .multi_key     (multi_key),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   always #5 clock = ~clock;

   typedef struct {
      int              cyc;
      logic [ROWS-1:0] s;
      logic            any;
      logic            multi;
      logic            press;
      logic            rel;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   task automatic report(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model: a commit happens when the synchronised value differs from
   // the committed one and has been seen on DEB consecutive edges.
   initial begin : model
      logic [ROWS-1:0] rowhist[$];
      logic [ROWS-1:0] s, last_s, model_s;
      int              run;
      exp_t            e;
      for (int i = 0; i < SYNC; i++) rowhist.push_back('0);
      last_s = '0; model_s = '0; run = 0;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            sbq.delete();
            rowhist.delete();
            for (int i = 0; i < SYNC; i++) rowhist.push_back('0);
            last_s = '0; model_s = '0; run = 0;
         end else begin
            cyc++;
            s = rowhist[SYNC-1];
            rowhist.push_front(row);
            void'(rowhist.pop_back());
            run    = (s == last_s) ? run + 1 : 1;
            last_s = s;
            if (s != model_s && run == DEB) begin
               e.cyc   = cyc;
               e.s     = s;
               e.any   = (s != 0);
               e.multi = ($countones(s) > 1);
               e.press = (model_s == 0);
               e.rel   = (s == 0);
               sbq.push_back(e);
               model_s = s;
            end
         end
      end
   end

   initial begin : monitor
      exp_t hold, e;
      logic evt, overdue;
      hold = '{cyc: 0, s: '0, any: 1'b0, multi: 1'b0, press: 1'b0, rel: 1'b0};
      forever begin
         @(negedge clock);
         if (reset) begin
            hold = '{cyc: 0, s: '0, any: 1'b0, multi: 1'b0, press: 1'b0, rel: 1'b0};
         end else begin
            overdue = (sbq.size() > 0) && (sbq[0].cyc < cyc);
            evt     = (s_row != hold.s) || press_pulse || release_pulse;
            if (evt || overdue) begin
               if (sbq.size() == 0) begin
                  total++;
                  bad++;
                  if (bad <= 30)
                     $display("FAIL unexpected_output: got s_row=%b press=%b release=%b expected no change (cycle %0d)",
                              s_row, press_pulse, release_pulse, cyc);
               end else begin
                  e = sbq.pop_front();
                  report("commit", {4'b0, 20'(cyc), s_row, any_key, multi_key, press_pulse, release_pulse},
                                   {4'b0, 20'(e.cyc), e.s, e.any, e.multi, e.press, e.rel});
                  hold = e;
               end
            end else begin
               report("steady", {24'b0, s_row, any_key, multi_key, press_pulse, release_pulse},
                                {24'b0, hold.s, hold.any, hold.multi, 2'b00});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin : stimulus
      logic [ROWS-1:0] picks[4];
      picks[0] = 4'b0000; picks[1] = 4'b0100; picks[2] = 4'b0110; picks[3] = 4'b0010;

      // Reset held with all rows active
      row   = 4'b1111;
      reset = 1'b1;
      tick(3);
      report("reset_hold", {24'b0, s_row, any_key, multi_key, press_pulse, release_pulse}, 32'h0);
      reset = 1'b0;
      tick(8);

      // Asynchronous reset in the middle of a debounce window
      row = 4'b0101;
      tick(4);
      reset = 1'b1;
      #1;
      report("reset_mid_check", {24'b0, s_row, any_key, multi_key, press_pulse, release_pulse}, 32'h0);
      tick(2);
      reset = 1'b0;
      tick(10);

      // Clean press
      row = 4'b0000; tick(10);
      row = 4'b0100; tick(10);

      // Bounce, then settle pressed
      row = 4'b0000; tick(10);
      for (int i = 0; i < 10; i++) begin
         row = (i % 2 == 0) ? 4'b0100 : 4'b0000;
         tick(2);
      end
      row = 4'b0100; tick(10);

      // Glitch from released
      row = 4'b0000; tick(10);
      row = 4'b0100; tick(2);
      row = 4'b0000; tick(10);

      // Key change between non-zero vectors
      row = 4'b0100; tick(10);
      row = 4'b0110; tick(10);

      // Release
      row = 4'b0010; tick(10);
      row = 4'b0000; tick(10);

      // Randomised holds of mixed length
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 3) == 0) row = 4'($urandom_range(0, 15));
         else                           row = picks[$urandom_range(0, 3)];
         tick($urandom_range(1, 7));
      end

      tick(12);
      report("queue_drained", 32'(sbq.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_row_debouncer.md
# keypad_row_debouncer

Parametrised row-input conditioner for the hexadecimal keypad scanner. It sits between the raw row pins and the scan/encode FSM. It synchronises an N-bit row vector through a configurable flop chain, debounces the vector as a whole, and presents a stable row vector. It also provides any-key and multi-key flags and one-cycle press/release event pulses, so the scanner never acts on metastable or bouncing inputs.

## Interface
Parameters:
- ROWS, default 4: row vector width, minimum 1.
- SYNC_STAGES, default 2: synchroniser depth, minimum 2.
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to commit, minimum 2. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clock, input, 1: all logic on rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- row, input, ROWS: raw asynchronous row lines, active-high.
- s_row, output, ROWS: debounced committed row vector.
- any_key, output, 1: registered OR-reduction of s_row.
- multi_key, output, 1: registered flag, set when more than one bit of s_row is set.
- press_pulse, output, 1: one-cycle pulse when the committed vector goes from zero to non-zero.
- release_pulse, output, 1: one-cycle pulse when the committed vector goes from non-zero to zero.

## Operation
- Reset clears all synchroniser flops, candidate, counter, s_row, any_key, multi_key, press_pulse and release_pulse to 0. It also forces the FSM to IDLE. Reset takes effect immediately, including mid-debounce.
- Synchroniser: each row bit passes through SYNC_STAGES flops; the last stage is sync_row. The vector is not combined before synchronisation.
- FSM has two states:
  - IDLE: sync_row == s_row.
    - If sync_row != s_row: candidate <= sync_row, cnt <= 1, go to CHECK.
  - CHECK: evaluated in priority order each edge:
    1. If sync_row == s_row: the bounce is cancelled; cnt <= 0, go to IDLE, no outputs change.
    2. Else if sync_row != candidate: candidate <= sync_row, cnt <= 1, stay in CHECK (restart).
    3. Else if cnt == DEBOUNCE_CYCLES-1: commit (see below), cnt <= 0, go to IDLE.
    4. Else: cnt <= cnt+1.
- Commit edge updates, all on the same edge:
  - s_row <= candidate.
  - any_key <= |candidate.
  - multi_key <= popcount(candidate) > 1.
  - press_pulse <= (s_row == 0) && (candidate != 0).
  - release_pulse <= (s_row != 0) && (candidate == 0).
- Pulses self-clear on the following edge.
- A change between two non-zero vectors (e.g. 0100 to 0110) commits with neither pulse asserted.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.

## Timing
- Count edges from edge 1, the first rising edge that samples a new row value.
- sync_row shows the new value after edge SYNC_STAGES.
- CHECK is entered at edge SYNC_STAGES+1.
- The commit occurs at edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge 18; with the test configuration (2/4) it is edge 6.
- Any deviation of sync_row inside the window restarts or cancels the debounce, per the CHECK rules.
- Outputs are registered only; there is no combinational path from row to any output.
- press_pulse and release_pulse are exactly one cycle wide and never assert simultaneously.

## Structure
- Package keypad_scan_pkg holds:
  - debounce_state_t, an enum with IDLE and CHECK.
  - Default parameter constants shared with the scanner: ROWS_DEFAULT=4, SYNC_STAGES_DEFAULT=2, DEBOUNCE_CYCLES_DEFAULT=16.
- One sub-module, bit_synchronizer. It has parameters WIDTH and STAGES and an asynchronous active-high reset, and is instantiated once with WIDTH=ROWS.
- The debounce FSM, counter and output registers stay in keypad_row_debouncer.

## Test plan
Configuration for all tests: ROWS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset: assert reset with row=1111 held → all outputs 0. Release reset, hold 1111 → s_row=1111, any_key=1, multi_key=1, press_pulse high one cycle at edge 6. Assert reset mid-CHECK → all outputs 0 immediately.
- Clean press: row 0000→0100 held → s_row=0100, any_key=1, multi_key=0, press_pulse=1 for exactly the cycle after edge 6.
- Bounce: row toggles 0100/0000 every 2 cycles for 20 cycles, then holds 0100 → no s_row change or pulse during toggling; commit at edge 6 after the final transition.
- Glitch: from committed 0000, row=0100 for 2 cycles then back to 0000 → FSM returns to IDLE, s_row stays 0000, no pulses.
- Key change: committed 0100, row→0110 held → s_row=0110 at edge 6, multi_key=1, press_pulse=0, release_pulse=0.
- Release: committed 0010, row→0000 held → s_row=0000, any_key=0, release_pulse=1 for one cycle at edge 6.
